axi_ram_slave: RTL

AXI3 responder backing the core's external bus with on-chip word RAM. Serves the core's ar/r/aw/w/b channels directly, replacing the SoC crossbar in unit and core-level sims. Runs independent read and write FSMs with one outstanding transaction per direction and INCR bursts. Byte writes are applied through wstrb.

---
 rtl/axi_ram_pkg.sv | 9 +
 rtl/axi_ram_mem.sv | 28 ++
 rtl/axi_ram_slave.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_pkg.sv
// rtl/axi_ram_pkg.sv - FSM state types and response code shared by the AXI RAM responder
package axi_ram_pkg;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wr_state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_ram_mem.sv
// rtl/axi_ram_mem.sv - 2^ADDR_W x 32 word RAM, byte-enable write port, asynchronous read port
module axi_ram_mem #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI3 RAM responder, one outstanding INCR burst per direction
// Defining AXI_RAM_WAIT_EN inserts WAIT_CYC stall cycles before the first R beat and before B.
module axi_ram_slave
    import axi_ram_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int WAIT_CYC = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [ADDR_W-1:0] IDX_ONE = 1;

    rd_state_t         rd_state;
    wr_state_t         wr_state;
    logic [ADDR_W-1:0] rd_idx, wr_idx;
    logic [3:0]        rd_cnt, wr_cnt;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic              unused;
`ifdef AXI_RAM_WAIT_EN
    logic [3:0]        rd_wait, wr_wait;
`endif

    // Write lands at the clock edge, so a same-cycle read of that word still sees the old value.
    assign mem_we = wready && wvalid && !reset;
    assign rdata  = rvalid ? mem_rdata : 32'h0;
    assign rresp  = RESP_OKAY;
    assign bresp  = RESP_OKAY;

`ifdef AXI_RAM_WAIT_EN
    assign unused = ^{wlast, arlen[7:4], awlen[7:4], araddr[31:ADDR_W+2], araddr[1:0],
                      awaddr[31:ADDR_W+2], awaddr[1:0]};
`else
    assign unused = ^{4'(WAIT_CYC), wlast, arlen[7:4], awlen[7:4], araddr[31:ADDR_W+2],
                      araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0]};
`endif

    axi_ram_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_idx),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= R_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= 4'h0;
            rd_idx   <= '0;
            rd_cnt   <= 4'h0;
`ifdef AXI_RAM_WAIT_EN
            rd_wait  <= 4'h0;
`endif
        end else begin
            case (rd_state)
                R_IDLE: if (arvalid) begin
                    rid     <= arid;
                    rd_idx  <= araddr[ADDR_W+1:2];
                    rd_cnt  <= arlen[3:0];
                    arready <= 1'b0;
`ifdef AXI_RAM_WAIT_EN
                    if (WAIT_CYC != 0) begin
                        rd_state <= R_WAIT;
                        rd_wait  <= 4'h0;
                    end else begin
                        rd_state <= R_DATA;
                        rvalid   <= 1'b1;
                        rlast    <= (arlen[3:0] == 4'd0);
                    end
`else
                    rd_state <= R_DATA;
                    rvalid   <= 1'b1;
                    rlast    <= (arlen[3:0] == 4'd0);
`endif
                end
`ifdef AXI_RAM_WAIT_EN
                R_WAIT: if (rd_wait == 4'(WAIT_CYC - 1)) begin
                    rd_state <= R_DATA;
                    rvalid   <= 1'b1;
                    rlast    <= (rd_cnt == 4'd0);
                end else begin
                    rd_wait <= rd_wait + 4'd1;
                end
`endif
                R_DATA: if (rready) begin
                    if (rlast) begin
                        rd_state <= R_IDLE;
                        rvalid   <= 1'b0;
                        rlast    <= 1'b0;
                        arready  <= 1'b1;
                    end else begin
                        rd_idx <= rd_idx + IDX_ONE;
                        rd_cnt <= rd_cnt - 4'd1;
                        rlast  <= (rd_cnt == 4'd1);
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // wlast is not trusted; the beat counter alone closes the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= W_IDLE;
            awready  <= 1'b1;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= 4'h0;
            wr_idx   <= '0;
            wr_cnt   <= 4'h0;
`ifdef AXI_RAM_WAIT_EN
            wr_wait  <= 4'h0;
`endif
        end else begin
            case (wr_state)
                W_IDLE: if (awvalid) begin
                    bid      <= awid;
                    wr_idx   <= awaddr[ADDR_W+1:2];
                    wr_cnt   <= awlen[3:0];
                    awready  <= 1'b0;
                    wready   <= 1'b1;
                    wr_state <= W_DATA;
                end
                W_DATA: if (wvalid) begin
                    if (wr_cnt == 4'd0) begin
                        wready <= 1'b0;
`ifdef AXI_RAM_WAIT_EN
                        if (WAIT_CYC != 0) begin
                            wr_state <= W_WAIT;
                            wr_wait  <= 4'h0;
                        end else begin
                            wr_state <= W_RESP;
                            bvalid   <= 1'b1;
                        end
`else
                        wr_state <= W_RESP;
                        bvalid   <= 1'b1;
`endif
                    end else begin
                        wr_idx <= wr_idx + IDX_ONE;
                        wr_cnt <= wr_cnt - 4'd1;
                    end
                end
`ifdef AXI_RAM_WAIT_EN
                W_WAIT: if (wr_wait == 4'(WAIT_CYC - 1)) begin
                    wr_state <= W_RESP;
                    bvalid   <= 1'b1;
                end else begin
                    wr_wait <= wr_wait + 4'd1;
                end
`endif
                W_RESP: if (bready) begin
                    bvalid   <= 1'b0;
                    awready  <= 1'b1;
                    wr_state <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

endmodule
